// File: rtl/mcoc_fetch_pkg.sv
// Shared types and constants for the mcoc_fetch32 instruction-fetch block.
package mcoc_fetch_pkg;

  typedef logic [15:0] halfword_t;

  // Read size select driven on fcmdl.
  localparam logic FC_16 = 1'b0;
  localparam logic FC_32 = 1'b1;

  // Instructions are halfword aligned, so redirect targets drop bit 0.
  localparam logic [15:0] REDIR_MASK = 16'hFFFE;

  localparam int DEPTH_DEFAULT = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mcoc_fetch32_if.sv
// Fetch-bus and decoder-side signals of mcoc_fetch32, grouped for port binding.
interface mcoc_fetch32_if;
  import mcoc_fetch_pkg::*;

  logic [15:0] fadr;
  logic        fcmdl;
  logic        freq;
  logic [31:0] fdat;
  logic        redir;
  logic [15:0] radr;
  halfword_t   inst;
  logic [15:0] ipc;
  logic        ivld;
  logic        iack;

  // Decoder handshake: a halfword transfers in any cycle with ivld && iack
  // (and no redir). ivld never depends on iack; inst/ipc stay stable while
  // ivld && !iack, and iack is ignored whenever ivld is low.
  modport master (
    output fadr, fcmdl, freq, inst, ipc, ivld,
    input  fdat, redir, radr, iack
  );

  modport slave (
    input  fadr, fcmdl, freq, inst, ipc, ivld,
    output fdat, redir, radr, iack
  );

endinterface

// File: rtl/mcoc_fetch_fifo.sv
// Halfword prefetch queue: push 0/1/2 halfwords (din0 first), pop one, sync flush.
module mcoc_fetch_fifo
  import mcoc_fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  push_n,
  input  halfword_t   din0,
  input  halfword_t   din1,
  input  logic        pop,
  output halfword_t   head,
  output logic [PW:0] count
);

  localparam int CW = PW + 1;

  halfword_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push_n) - CW'(pop);
    end
  end

  // Storage is not reset; only entries below count are ever read out.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push_n != 2'd0) mem[wr_ptr] <= din0;
      if (push_n == 2'd2) mem[wr_ptr + PW'(1)] <= din1;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mcoc_fetch32.sv
// Instruction-fetch initiator: credit-based issue, 1-cycle read pipeline, redirect flush.
// Optional macro MCOC_FETCH_BYPASS_EN presents a response straight from fdat when the queue is empty.
module mcoc_fetch32
  import mcoc_fetch_pkg::*;
#(
  parameter int          DEPTH   = DEPTH_DEFAULT,
  parameter logic [15:0] RST_VEC = 16'h0000
) (
  input  logic           clk,
  input  logic           rst,
  mcoc_fetch32_if.master bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = PW + 2;

  logic [15:0]   npc, ipc_q, fadr_q;
  logic          fcmdl_q, freq_q;
  logic          rsp_vld, rsp_32, rsp_stale;

  logic [CW-1:0] q_count;
  halfword_t     q_head;
  logic          q_empty;

  logic [15:0]   tgt, eff_npc;
  logic [FW-1:0] used, free;
  logic          iss_32, iss_16, issue;

  logic          rsp_ok;
  halfword_t     hw_a, hw_b, din0, inst_c;
  logic [1:0]    push_n;
  logic          ivld_c, pop_any, q_pop;
`ifdef MCOC_FETCH_BYPASS_EN
  logic          byp;
`endif

  assign q_empty = (q_count == '0);

  // Credit counts queued halfwords plus every live read in flight, so the
  // queue can never overflow. A redirect frees everything in the same cycle.
  always_comb begin
    tgt     = bus.radr & REDIR_MASK;
    eff_npc = bus.redir ? tgt : npc;
    used    = '0;
    if (!bus.redir) begin
      used = FW'(q_count);
      if (freq_q)                used = used + (fcmdl_q ? FW'(2) : FW'(1));
      if (rsp_vld && !rsp_stale) used = used + (rsp_32  ? FW'(2) : FW'(1));
    end
    free   = FW'(DEPTH) - used;
    iss_32 = !eff_npc[1] && (free >= FW'(2));
    iss_16 = eff_npc[1] ? (free >= FW'(1)) : (free == FW'(1));
    issue  = iss_32 || iss_16;
  end

  always_comb begin
    rsp_ok  = rsp_vld && !rsp_stale && !bus.redir;
    hw_a    = rsp_32 ? bus.fdat[31:16] : bus.fdat[15:0];
    hw_b    = bus.fdat[15:0];
    push_n  = rsp_ok ? (rsp_32 ? 2'd2 : 2'd1) : 2'd0;
    din0    = hw_a;
`ifdef MCOC_FETCH_BYPASS_EN
    byp     = rsp_ok && q_empty;
    ivld_c  = !q_empty || byp;
    inst_c  = !q_empty ? q_head : (byp ? hw_a : '0);
    pop_any = ivld_c && bus.iack && !bus.redir;
    q_pop   = pop_any && !q_empty;
    // A bypassed halfword taken this cycle never enters the queue.
    if (pop_any && byp) begin
      push_n = rsp_32 ? 2'd1 : 2'd0;
      din0   = hw_b;
    end
`else
    ivld_c  = !q_empty;
    inst_c  = ivld_c ? q_head : '0;
    pop_any = ivld_c && bus.iack && !bus.redir;
    q_pop   = pop_any;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      npc       <= RST_VEC;
      ipc_q     <= RST_VEC;
      fadr_q    <= RST_VEC;
      fcmdl_q   <= FC_16;
      freq_q    <= 1'b0;
      rsp_vld   <= 1'b0;
      rsp_32    <= 1'b0;
      rsp_stale <= 1'b0;
    end else begin
      freq_q    <= issue;
      rsp_vld   <= freq_q;
      rsp_32    <= fcmdl_q;
      // The read on the bus during a redirect returns next cycle as stale.
      rsp_stale <= bus.redir;
      if (issue) begin
        fadr_q  <= eff_npc;
        fcmdl_q <= iss_32 ? FC_32 : FC_16;
        npc     <= eff_npc + (iss_32 ? 16'd4 : 16'd2);
      end else begin
        npc     <= eff_npc;
      end
      if (bus.redir)    ipc_q <= tgt;
      else if (pop_any) ipc_q <= ipc_q + 16'd2;
    end
  end

  mcoc_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (bus.redir),
    .push_n (push_n),
    .din0   (din0),
    .din1   (hw_b),
    .pop    (q_pop),
    .head   (q_head),
    .count  (q_count)
  );

  assign bus.fadr  = fadr_q;
  assign bus.fcmdl = fcmdl_q;
  assign bus.freq  = freq_q;
  assign bus.inst  = inst_c;
  assign bus.ipc   = ipc_q;
  assign bus.ivld  = ivld_c;

endmodule

// File: tb/tb_mcoc_fetch32.sv
// Directed bench for mcoc_fetch32 with a PC-level stream model and a 1-cycle ROM responder.
module tb_mcoc_fetch32;

  localparam int          DEPTH   = 4;
  localparam logic [15:0] RST_VEC = 16'h0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcoc_fetch32_if bus();

  mcoc_fetch32 #(.DEPTH(DEPTH), .RST_VEC(RST_VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic        iack_v, redir_v;
  logic [15:0] radr_v;
  logic        pend_v;
  logic [31:0] pend_d;
  logic [15:0] m_pc, m_fptr, ahead;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] resp(input logic [15:0] a, input logic c32);
    logic [15:0] a2;
    a2 = a + 16'd2;
    return c32 ? {a ^ 16'h5A00, a2 ^ 16'h5A00} : {16'hDEAD, a ^ 16'h5A00};
  endfunction

  // One clock: drive inputs just after the rising edge, sample at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus.fdat  = pend_v ? pend_d : 32'hDEAD_BEEF;
    bus.iack  = iack_v;
    bus.redir = redir_v;
    bus.radr  = radr_v;
    @(negedge clk);
    pend_v = bus.freq && !rst;
    pend_d = resp(bus.fadr, bus.fcmdl);
  endtask

  task automatic wait_ivld(input string name, input int budget, output bit ok);
    int n;
    n = 0;
    while (bus.ivld !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    ok = (bus.ivld === 1'b1);
    if (!ok) chk(name, {31'b0, bus.ivld}, 32'd1);
  endtask

  // Expects each queued PC to be presented in order, consuming one per cycle.
  task automatic drain(input string name, input int budget);
    logic [15:0] e;
    bit ok;
    while (exp_q.size() > 0) begin
      wait_ivld($sformatf("%s_timeout", name), budget, ok);
      if (!ok) begin
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      chk($sformatf("%s_ipc", name), {16'h0, bus.ipc}, {16'h0, e});
      chk($sformatf("%s_inst", name), {16'h0, bus.inst}, {16'h0, e ^ 16'h5A00});
      step();
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk($sformatf("%s_fadr", name),  {16'h0, bus.fadr}, {16'h0, RST_VEC});
    chk($sformatf("%s_ipc", name),   {16'h0, bus.ipc},  {16'h0, RST_VEC});
    chk($sformatf("%s_fcmdl", name), {31'b0, bus.fcmdl}, 32'd0);
    chk($sformatf("%s_freq", name),  {31'b0, bus.freq},  32'd0);
    chk($sformatf("%s_ivld", name),  {31'b0, bus.ivld},  32'd0);
    chk($sformatf("%s_inst", name),  {16'h0, bus.inst},  32'd0);
  endtask

  // Stream model: the consumer sees consecutive halfwords from the last
  // target, inst = f(ipc); requests walk the same addresses and never run
  // more than DEPTH halfwords ahead of the consumer.
  always @(negedge clk) begin
    if (rst) begin
      m_pc   = RST_VEC;
      m_fptr = RST_VEC;
    end else begin
      if (bus.ivld) begin
        chk("stream_ipc",  {16'h0, bus.ipc},  {16'h0, m_pc});
        chk("stream_inst", {16'h0, bus.inst}, {16'h0, m_pc ^ 16'h5A00});
      end
      if (bus.freq) begin
        chk("fetch_adr", {16'h0, bus.fadr}, {16'h0, m_fptr});
        if (bus.fcmdl) chk("fetch32_align", {31'b0, bus.fadr[1]}, 32'd0);
        m_fptr = m_fptr + (bus.fcmdl ? 16'd4 : 16'd2);
        ahead  = m_fptr - m_pc;
        chk("fetch_credit", {31'b0, (ahead > 16'(2 * DEPTH))}, 32'd0);
      end
      if (bus.ivld && bus.iack && !bus.redir) m_pc = m_pc + 16'd2;
      if (bus.redir) begin
        m_pc   = bus.radr & 16'hFFFE;
        m_fptr = bus.radr & 16'hFFFE;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int gaps;
    int nreq;
    rst       = 1'b1;
    iack_v    = 1'b1;
    redir_v   = 1'b0;
    radr_v    = 16'h0000;
    pend_v    = 1'b0;
    pend_d    = '0;
    bus.fdat  = '0;
    bus.iack  = 1'b1;
    bus.redir = 1'b0;
    bus.radr  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    #1 rst = 1'b0;

    // 1: streaming from reset with iack held high
    step();
    chk("t1_freq",  {31'b0, bus.freq},  32'd1);
    chk("t1_fadr",  {16'h0, bus.fadr},  32'h0000);
    chk("t1_fcmdl", {31'b0, bus.fcmdl}, 32'd1);
    exp_q = {16'h0000, 16'h0002, 16'h0004};
    drain("t1", 6);
    gaps = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.ivld !== 1'b1) gaps++;
      step();
    end
    chk("t1_gaps", gaps, 0);

    // 2: consumer stalls, queue fills with exactly two 32-bit reads
    redir_v = 1'b1;
    radr_v  = 16'h0200;
    iack_v  = 1'b0;
    step();
    redir_v = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.freq === 1'b1) nreq++;
    end
    chk("t2_reads", nreq, 2);
    chk("t2_hold_ivld", {31'b0, bus.ivld}, 32'd1);
    chk("t2_hold_ipc",  {16'h0, bus.ipc},  32'h0200);
    iack_v = 1'b1;
    step();
    exp_q = {16'h0200, 16'h0202, 16'h0204, 16'h0206, 16'h0208, 16'h020A};
    drain("t2", 4);

    // 3: redirect to an odd-halfword target
    redir_v = 1'b1;
    radr_v  = 16'h0103;
    step();
    redir_v = 1'b0;
    step();
    chk("t3_freq",  {31'b0, bus.freq},  32'd1);
    chk("t3_fadr",  {16'h0, bus.fadr},  32'h0102);
    chk("t3_fcmdl", {31'b0, bus.fcmdl}, 32'd0);
    chk("t3_ivld_t1", {31'b0, bus.ivld}, 32'd0);
    step();
    chk("t3_fadr2",  {16'h0, bus.fadr},  32'h0104);
    chk("t3_fcmdl2", {31'b0, bus.fcmdl}, 32'd1);
`ifdef MCOC_FETCH_BYPASS_EN
    chk("t3_ivld_t2", {31'b0, bus.ivld}, 32'd1);
`else
    chk("t3_ivld_t2", {31'b0, bus.ivld}, 32'd0);
    step();
    chk("t3_ivld_t3", {31'b0, bus.ivld}, 32'd1);
`endif
    chk("t3_inst", {16'h0, bus.inst}, 32'h5B02);
    chk("t3_ipc",  {16'h0, bus.ipc},  32'h0102);

    // 4: redirect while two reads are in flight, then back-to-back redirects
    redir_v = 1'b1;
    radr_v  = 16'h0400;
    step();
    redir_v = 1'b0;
    step();
    redir_v = 1'b1;
    radr_v  = 16'h0801;
    step();
    chk("t4_busy", {31'b0, bus.freq}, 32'd1);
    redir_v = 1'b0;
    exp_q = {16'h0800, 16'h0802};
    drain("t4", 6);
    redir_v = 1'b1;
    radr_v  = 16'h1000;
    step();
    radr_v  = 16'h2003;
    step();
    redir_v = 1'b0;
    exp_q = {16'h2002, 16'h2004};
    drain("t4b", 6);

    // 5: wrap through the top of the address space
    redir_v = 1'b1;
    radr_v  = 16'hFFFC;
    step();
    redir_v = 1'b0;
    step();
    chk("t5_fadr",  {16'h0, bus.fadr},  32'hFFFC);
    chk("t5_fcmdl", {31'b0, bus.fcmdl}, 32'd1);
    step();
    chk("t5_fadr2",  {16'h0, bus.fadr},  32'h0000);
    chk("t5_fcmdl2", {31'b0, bus.fcmdl}, 32'd1);
    exp_q = {16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
    drain("t5", 4);

    // 6: asynchronous reset in the middle of streaming
    repeat (3) step();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_reset_outputs("t6_async");
    @(negedge clk);
    #1;
    rst    = 1'b0;
    pend_v = 1'b0;
    step();
    chk("t6_freq",  {31'b0, bus.freq},  32'd1);
    chk("t6_fadr",  {16'h0, bus.fadr},  {16'h0, RST_VEC});
    chk("t6_fcmdl", {31'b0, bus.fcmdl}, 32'd1);
    exp_q = {RST_VEC, RST_VEC + 16'd2};
    drain("t6", 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
